// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Adds two WIDTH-bit operands one nibble per clock, LSB nibble first, by
// time-sharing an external combinational 4-bit ripple adder. The operands
// and the running carry are held locally. Each RUN cycle presents one nibble
// pair to the adder and captures S/cOut back into the result register.
// Optional feature macro: OVERFLOW_FLAG_EN adds a registered two's-complement
// overflow flag output (ovf), which is updated when the add completes.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               w_accept;
    logic               w_last;
    logic [IDX_W+1:0]   w_bit_base;

    // Two's-complement overflow: like-signed operands whose sum flips sign.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign w_bit_base = {r_idx, 2'b00};
    assign sum        = r_sum;
    assign c_out      = r_cout;

    // Start is only honoured when not mid-operation; last nibble step detect.
    always_comb begin
        w_accept = 1'b0;
        w_last   = 1'b0;
        if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
            w_accept = start;
        end
        if ((r_state == S_RUN) && (r_idx == LAST_IDX)) begin
            w_last = 1'b1;
        end
    end

    // Next-state logic and status/adder-drive outputs (adder inputs idle at 0).
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                add_a   = r_a[w_bit_base +: 4];
                add_b   = r_b[w_bit_base +: 4];
                add_cin = r_carry;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = w_accept ? S_RUN : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture on accept, then one nibble of result per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_sum[w_bit_base +: 4] <= add_s;
            r_carry                <= add_cout;
            if (w_last) begin
                r_cout <= add_cout;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic r_ovf;

    assign ovf = r_ovf;

    // Overflow flag is judged from the top nibble's sum bit on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= ovf_calc(r_a[WIDTH-1], r_b[WIDTH-1], add_s[3]);
        end
    end
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural
// stand-in for the shared 4-bit ripple adder.
`timescale 1ns/1ps
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_s;
    logic             add_cout;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    int checks;
    int failures;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

    // External 4-bit adder stand-in.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for exactly one rising edge.
    task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        @(negedge clk);
        a     = va;
        b     = vb;
        c_in  = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count negedges after launch until done is seen (0 if never, bounded).
    task automatic wait_done(output int at, output int busy_cnt);
        at       = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                at = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; c_in = 1'b0;
        #2;
        checks++;
        if ({busy, done, sum, c_out, add_a, add_b, add_cin} !== 28'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h c_out=%b add_a=%h add_b=%h add_cin=%b, want all 0",
                     busy, done, sum, c_out, add_a, add_b, add_cin);
        end
`ifdef OVERFLOW_FLAG_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int at, bc;
        launch(16'h1234, 16'h4321, 1'b0);
        wait_done(at, bc);
        checks++;
        if (at !== 5) begin
            failures++;
            $display("FAIL basic_latency: done at cycle %0d want 5", at);
        end
        checks++;
        if (bc !== 4) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d want 4", bc);
        end
        checks++;
        if (sum !== 16'h5555 || c_out !== 1'b0) begin
            failures++;
            $display("FAIL basic_sum: got %h c_out=%b want 5555 c_out=0", sum, c_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_in_done: got %b want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sum !== 16'h5555) begin
            failures++;
            $display("FAIL basic_done_pulse_hold: done=%b sum=%h want 0 5555", done, sum);
        end
    endtask

    task automatic test_ripple();
        logic [3:0] cins;
        int at;
        cins = 4'h0;
        launch(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cins[i] = add_cin;
            if (i == 0) begin
                checks++;
                if (add_a !== 4'hF || add_b !== 4'h1) begin
                    failures++;
                    $display("FAIL ripple_first_nibble: add_a=%h add_b=%h want F 1", add_a, add_b);
                end
            end
        end
        checks++;
        if (cins !== 4'b1110) begin
            failures++;
            $display("FAIL ripple_cin_seq: got %b (idx3..0) want 1110", cins);
        end
        at = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) begin
                at = 1;
                break;
            end
        end
        checks++;
        if (at !== 1 || sum !== 16'h0000 || c_out !== 1'b1) begin
            failures++;
            $display("FAIL ripple_sum: done_seen=%0d sum=%h c_out=%b want 1 0000 1", at, sum, c_out);
        end
        @(negedge clk);
        checks++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
            failures++;
            $display("FAIL ripple_idle_adder: add_a=%h add_b=%h add_cin=%b want 0 0 0", add_a, add_b, add_cin);
        end
    endtask

    task automatic test_back_to_back();
        int at, bc;
        launch(16'h00FF, 16'h0000, 1'b1);
        // Hold start high with junk operands through RUN.
        a     = 16'h1111;
        b     = 16'h1111;
        c_in  = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) begin
                a = 16'h8000;
                b = 16'h8000;
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || sum !== 16'h0100 || c_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: done=%b sum=%h c_out=%b want 1 0100 0", done, sum, c_out);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_relaunch: busy=%b want 1", busy);
        end
        wait_done(at, bc);
        checks++;
        if (at !== 4 || sum !== 16'h0000 || c_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: done at %0d sum=%h c_out=%b want 4 0000 1", at, sum, c_out);
        end
    endtask

    task automatic test_reset_midrun();
        int at, bc, seen;
        launch(16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, c_out, add_a, add_b, add_cin} !== 28'd0) begin
            failures++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h c_out=%b add_a=%h add_b=%h add_cin=%b want all 0",
                     busy, done, sum, c_out, add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midrun_no_done: activity seen=%0d want 0", seen);
        end
        launch(16'h0001, 16'h0001, 1'b0);
        wait_done(at, bc);
        checks++;
        if (at !== 5 || sum !== 16'h0002 || c_out !== 1'b0) begin
            failures++;
            $display("FAIL midrun_recover: done at %0d sum=%h c_out=%b want 5 0002 0", at, sum, c_out);
        end
    endtask

`ifdef OVERFLOW_FLAG_EN
    task automatic test_ovf();
        int at, bc;
        launch(16'h7FFF, 16'h0001, 1'b0);
        wait_done(at, bc);
        checks++;
        if (at !== 5 || sum !== 16'h8000 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_pos: done at %0d sum=%h ovf=%b want 5 8000 1", at, sum, ovf);
        end
        launch(16'hFFFF, 16'h0001, 1'b0);
        wait_done(at, bc);
        checks++;
        if (at !== 5 || sum !== 16'h0000 || ovf !== 1'b0 || c_out !== 1'b1) begin
            failures++;
            $display("FAIL ovf_none: done at %0d sum=%h ovf=%b c_out=%b want 5 0000 0 1", at, sum, ovf, c_out);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_ripple();
        test_back_to_back();
        test_reset_midrun();
`ifdef OVERFLOW_FLAG_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
